// File: rtl/kv_cell_controller_if.sv
// Host-side command/response handshake bundle for kv_cell_controller.
// A transfer happens on any rising edge where valid && ready; the sender holds its payload stable until then.
interface kv_cell_controller_if #(
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_value
    );

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
        output req_ready, resp_valid, resp_status, resp_value
    );
endinterface

// File: rtl/kv_cell_controller.sv
// GET/PUT/DEL controller that scans a key/value cell array one entry per cycle.
// Define KV_CTRL_EARLY_EXIT_EN to leave the scan the cycle after the first key hit.
module kv_cell_controller #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    kv_cell_controller_if.slave                req_if,
    output logic [NUM_ENTRIES-1:0]             cell_read_op,
    output logic [NUM_ENTRIES-1:0]             cell_write_op,
    output logic [KEY_WIDTH-1:0]               cell_key_in,
    output logic [VALUE_WIDTH-1:0]             cell_value_in,
    input  logic [NUM_ENTRIES*KEY_WIDTH-1:0]   cell_key_out,
    input  logic [NUM_ENTRIES*VALUE_WIDTH-1:0] cell_value_out,
    input  logic [NUM_ENTRIES-1:0]             cell_used,
    output logic [1:0]                         dbg_state
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);

    localparam logic [1:0] OP_GET = 2'd1;
    localparam logic [1:0] OP_PUT = 2'd2;
    localparam logic [1:0] OP_DEL = 2'd3;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_BAD  = 2'd3;

    typedef enum logic [1:0] {IDLE, SCAN, ACT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   hit_q, hit_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic                   free_q, free_d;
    logic [IDX_W-1:0]       free_idx_q, free_idx_d;
    logic [1:0]             status_q, status_d;
    logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;

    logic [KEY_WIDTH-1:0]   key_arr [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] val_arr [NUM_ENTRIES];

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            key_arr[i] = cell_key_out[i*KEY_WIDTH +: KEY_WIDTH];
            val_arr[i] = cell_value_out[i*VALUE_WIDTH +: VALUE_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            key_q      <= '0;
            value_q    <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
            status_q   <= '0;
            rvalue_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            value_q    <= value_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            free_q     <= free_d;
            free_idx_q <= free_idx_d;
            status_q   <= status_d;
            rvalue_q   <= rvalue_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        key_d         = key_q;
        value_d       = value_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        hit_idx_d     = hit_idx_q;
        free_d        = free_q;
        free_idx_d    = free_idx_q;
        status_d      = status_q;
        rvalue_d      = rvalue_q;
        cell_read_op  = '0;
        cell_write_op = '0;
        cell_key_in   = '0;
        cell_value_in = '0;

        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    op_d    = req_if.req_op;
                    key_d   = req_if.req_key;
                    value_d = req_if.req_value;
                    if (req_if.req_op == 2'd0 || req_if.req_key == '0) begin
                        status_d = ST_BAD;
                        rvalue_d = '0;
                        state_d  = RESP;
                    end else begin
                        idx_d   = '0;
                        hit_d   = 1'b0;
                        free_d  = 1'b0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                cell_read_op = ONE_HOT0 << idx_q;
                // Only the lowest matching / lowest empty entry is kept.
                if (cell_used[idx_q] && key_arr[idx_q] == key_q && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!cell_used[idx_q] && !free_q) begin
                    free_d     = 1'b1;
                    free_idx_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) state_d = ACT;
`ifdef KV_CTRL_EARLY_EXIT_EN
                if (hit_d) state_d = ACT;
`endif
            end
            ACT: begin
                state_d  = RESP;
                rvalue_d = '0;
                status_d = hit_q ? ST_OK : ST_MISS;
                case (op_q)
                    OP_GET: if (hit_q) rvalue_d = val_arr[hit_idx_q];
                    OP_PUT: begin
                        if (hit_q || free_q) begin
                            cell_write_op = ONE_HOT0 << (hit_q ? hit_idx_q : free_idx_q);
                            cell_key_in   = key_q;
                            cell_value_in = value_q;
                            status_d      = ST_OK;
                        end else begin
                            status_d = ST_FULL;
                        end
                    end
                    OP_DEL: if (hit_q) cell_write_op = ONE_HOT0 << hit_idx_q;
                    default: status_d = ST_BAD;
                endcase
            end
            RESP: begin
                if (req_if.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_if.req_ready   = (state_q == IDLE);
    assign req_if.resp_valid  = (state_q == RESP);
    assign req_if.resp_status = (state_q == RESP) ? status_q : 2'd0;
    assign req_if.resp_value  = (state_q == RESP) ? rvalue_q : '0;
    assign dbg_state          = state_q;
endmodule
